// File: rtl/lock_in_demod.sv
// Lock-in demodulator: multiplies the filtered error by the in-phase/quadrature references
// and emits one scaled, saturated I/Q mean per window of 2^int_pow accepted samples.
module lock_in_demod #(
  parameter int word_width = 16,
  parameter int int_pow    = 10,
  localparam int acc_width = 2 * word_width + int_pow
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         sample_valid,
  input  logic signed [word_width-1:0] sig_in,
  input  logic signed [word_width-1:0] ref_sin,
  input  logic signed [word_width-1:0] ref_cos,
  output logic signed [word_width-1:0] i_out,
  output logic signed [word_width-1:0] q_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         sat_flag
);
  localparam int prod_width = 2 * word_width;
  localparam int shift      = int_pow + word_width - 1;
  localparam logic signed [acc_width-1:0] sat_hi =
    {{(acc_width - word_width + 1){1'b0}}, {(word_width - 1){1'b1}}};
  localparam logic signed [acc_width-1:0] sat_lo = ~sat_hi;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_reg, state_next;

  logic keep, accept, start;
  logic [int_pow-1:0] count_reg;
  logic s1_valid_reg, s1_last_reg, s2_valid_reg, s2_last_reg;
  logic dump_valid_reg, out_valid_reg, sat_flag_reg;
  logic signed [word_width-1:0] s1_sig_reg;
  logic [1:0] clip;
  logic [1:0][word_width-1:0] res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run)  state_next = RUN;
      RUN:     if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_reg == RUN);
    start = (state_reg == IDLE) && run;
  end

  // keep low means idle or aborting: everything in flight is discarded on this edge
  assign keep   = (state_reg == RUN) && run;
  assign accept = keep && sample_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg      <= '0;
      s1_valid_reg   <= 1'b0;
      s1_last_reg    <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s2_last_reg    <= 1'b0;
      dump_valid_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      sat_flag_reg   <= 1'b0;
      s1_sig_reg     <= '0;
    end else begin
      if (accept) s1_sig_reg <= sig_in;
      if (!keep) begin
        count_reg      <= '0;
        s1_valid_reg   <= 1'b0;
        s1_last_reg    <= 1'b0;
        s2_valid_reg   <= 1'b0;
        s2_last_reg    <= 1'b0;
        dump_valid_reg <= 1'b0;
      end else begin
        if (accept) count_reg <= count_reg + 1'b1;
        s1_valid_reg   <= accept;
        s1_last_reg    <= accept && (&count_reg);
        s2_valid_reg   <= s1_valid_reg;
        s2_last_reg    <= s1_last_reg;
        dump_valid_reg <= s2_valid_reg && s2_last_reg;
      end
      out_valid_reg <= keep && dump_valid_reg;
      if (start)                                sat_flag_reg <= 1'b0;
      else if (keep && dump_valid_reg && |clip) sat_flag_reg <= 1'b1;
    end
  end

  // channel 0 uses the in-phase reference, channel 1 the quadrature reference
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [word_width-1:0] ref_reg;
    logic signed [prod_width-1:0] prod_reg;
    logic signed [acc_width-1:0]  acc_reg, sum_reg, scaled;
    logic signed [word_width-1:0] res_reg, res_next;
    logic                         clip_ch;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ref_reg  <= '0;
        prod_reg <= '0;
        acc_reg  <= '0;
        sum_reg  <= '0;
        res_reg  <= '0;
      end else begin
        if (accept) ref_reg <= (gi == 0) ? ref_sin : ref_cos;
        prod_reg <= prod_width'(s1_sig_reg) * prod_width'(ref_reg);
        if (!keep)             acc_reg <= '0;
        else if (s2_valid_reg) acc_reg <= s2_last_reg ? '0 : acc_reg + acc_width'(prod_reg);
        if (s2_valid_reg && s2_last_reg) sum_reg <= acc_reg + acc_width'(prod_reg);
        if (keep && dump_valid_reg) res_reg <= res_next;
      end
    end

    // window mean of Q15 products, clipped to the output word range
    always_comb begin
      scaled  = sum_reg >>> shift;
      clip_ch = (scaled > sat_hi) || (scaled < sat_lo);
      if (scaled > sat_hi)      res_next = sat_hi[word_width-1:0];
      else if (scaled < sat_lo) res_next = sat_lo[word_width-1:0];
      else                      res_next = scaled[word_width-1:0];
    end

    assign clip[gi] = clip_ch;
    assign res[gi]  = res_reg;
  end

  assign i_out     = res[0];
  assign q_out     = res[1];
  assign out_valid = out_valid_reg;
  assign sat_flag  = sat_flag_reg;
endmodule
